mem_arbiter_mp: RTL
===================

# mem_arbiter_mp

Parametrised multi-port arbiter in front of the single-ported synchronous data/instruction memory. It generalises the two-requester (fetch vs. data) arbitration to NUM_PORTS requesters with selectable fixed or round-robin priority, optional bus locking and a configurable memory read latency. It also routes returned read data back to the issuing port through a latency-matched return pipeline. It sits between the pipeline stages (fetch, execute/mem, later a DMA or debug port) and the memory pins of the cpu top.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesters (2..8); port 0 has highest fixed priority
- ADDR_WIDTH, 8, memory address width
- DATA_WIDTH, 16, memory data width
- READ_LATENCY, 1, cycles from accepted read to valid mem_value_i (1..4)
- PRIO_MODE, PRIO_RR, PRIO_FIXED or PRIO_RR (from mem_arb_pkg)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset; synchronous and active-high
- req_i  in  NUM_PORTS  per-port request, held until granted
- we_i  in  NUM_PORTS  per-port write (1) / read (0)
- lock_i  in  NUM_PORTS  keep grant for following cycle while req held
- addr_i  in  NUM_PORTS x ADDR_WIDTH  per-port address
- wdata_i  in  NUM_PORTS x DATA_WIDTH  per-port write data
- gnt_o  out  NUM_PORTS  one-hot grant, same cycle as accepted req
- rvalid_o  out  NUM_PORTS  one-hot read-data-valid to issuing port
- rdata_o  out  DATA_WIDTH  read data, shared by all ports
- mem_value_i  in  DATA_WIDTH  memory read data
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_value_o  out  DATA_WIDTH  memory write data
- mem_rd_en_o  out  1  memory read strobe
- mem_wr_en_o  out  1  memory write strobe
- mem_enable_o  out  1  mem_rd_en_o | mem_wr_en_o

## Operation
- At most one access per cycle. Winner is selected combinationally from req_i; gnt_o, mem_addr_o, mem_value_o, mem_rd_en_o/mem_wr_en_o are driven from the winner in the same cycle.
- No request: gnt_o=0, strobes 0, mem_addr_o/mem_value_o=0.
- Selection order: (1) lock owner if its req_i is high; (2) PRIO_FIXED: lowest index requesting; PRIO_RR: first requesting index at or after rr_ptr, wrapping NUM_PORTS-1 -> 0.
- rr_ptr updates to (winner+1) mod NUM_PORTS on every grant; unchanged on idle cycles and on lock-held grants.
- Lock: if granted port p has lock_i[p]=1, lock_owner<=p. Cleared when owner drops req_i or lock_i, or on reset. Locked owner never loses to another port.
- Read return: each granted read pushes {valid, port index} into a READ_LATENCY-deep shift register. At the tail, rvalid_o[idx]=valid; rdata_o=mem_value_i unconditionally.
- Writes generate no rvalid.
- Back-to-back reads from any ports are supported every cycle. Return order equals issue order.

## Timing
- Grant latency 0: req_i high at cycle n with win -> gnt_o high in cycle n.
- Read data latency: read granted in cycle n -> rvalid_o in cycle n+READ_LATENCY.
- Reset (rst_i high at edge): rr_ptr=0, lock_owner=none, return pipeline cleared.
- While rst_i high, gnt_o, rvalid_o and all strobes are forced 0; mem_addr_o, mem_value_o and rdata_o read 0.
- Reset mid-operation: in-flight reads are discarded and never signalled.
- A return and a new grant in the same cycle are independent; both occur.
- A port may receive rvalid_o and gnt_o in the same cycle.
- A request deasserted before grant is dropped; no state retained.

## Structure
- mem_arb_pkg: prio_mode_e {PRIO_FIXED, PRIO_RR}; function port_idx_w(n)=$clog2(n) (min 1); return-slot struct {valid, port idx}.
- Sub-module mem_arb_rr_picker: combinational request vector + start pointer -> one-hot grant and index. It is used for both modes; fixed mode uses pointer 0.
- Top holds rr_ptr, lock_owner, return pipeline and output muxing.

## Test plan
- NUM_PORTS=3, PRIO_FIXED: req_i=3'b111, all reads, for 3 cycles -> gnt_o=001 every cycle; port 0 gets rvalid_o 1 cycle later (READ_LATENCY=1).
- PRIO_RR, req_i=3'b111 held 6 cycles -> gnt_o sequence 001,010,100,001,010,100; then req_i=3'b100 -> 100 and rr_ptr=0.
- Lock: port 1 granted with lock_i[1]=1 and req_i=3'b011 held 4 cycles -> gnt_o=010 all 4 cycles. Drop lock_i[1] -> next grant follows RR (port 0).
- READ_LATENCY=3, reads from ports 2,0,1 in consecutive cycles with mem_value_i=0xA1,0xB2,0xC3 at cycles n+3..n+5 -> rvalid_o=100,001,010 with rdata_o=0xA1,0xB2,0xC3.
- Write from port 1, addr 0x3C, data 0xBEEF -> mem_wr_en_o=1, mem_enable_o=1, mem_addr_o=0x3C, mem_value_o=0xBEEF same cycle; no rvalid_o afterwards.
- READ_LATENCY=2, read issued at cycle n, rst_i high at n+1 -> no rvalid_o at n+2. rr_ptr=0 and lock cleared after reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the multi-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    PRIO_FIXED = 1'b0,
    PRIO_RR    = 1'b1
  } prio_mode_e;

  // Wide enough for the largest supported port count (8).
  localparam int IDX_MAX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] idx;
  } ret_slot_t;

  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr_picker.sv
// Combinational picker: first requesting index at or after ptr, wrapping N-1 -> 0.
module mem_arb_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // ptr is always < N, so one subtraction is enough to wrap.
  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[wrap(int'(ptr) + i)]) begin
        any                        = 1'b1;
        gnt[wrap(int'(ptr) + i)]   = 1'b1;
        idx                        = IW'(wrap(int'(ptr) + i));
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_mp.sv
// Multi-port arbiter in front of a single-ported synchronous memory, with lock
// support and a latency-matched read-return pipeline.
module mem_arbiter_mp
  import mem_arb_pkg::*;
#(
  parameter int         NUM_PORTS    = 2,
  parameter int         ADDR_WIDTH   = 8,
  parameter int         DATA_WIDTH   = 16,
  parameter int         READ_LATENCY = 1,
  parameter prio_mode_e PRIO_MODE    = PRIO_RR
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_PORTS-1:0]                 req_i,
  input  logic [NUM_PORTS-1:0]                 we_i,
  input  logic [NUM_PORTS-1:0]                 lock_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]                 gnt_o,
  output logic [NUM_PORTS-1:0]                 rvalid_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  input  logic [DATA_WIDTH-1:0]                mem_value_i,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  output logic [DATA_WIDTH-1:0]                mem_value_o,
  output logic                                 mem_rd_en_o,
  output logic                                 mem_wr_en_o,
  output logic                                 mem_enable_o
);

  // Handshake: a port holds req_i (with we_i/addr_i/wdata_i stable) until it
  // sees gnt_o in the same cycle; that cycle is the transfer. Reads return
  // exactly READ_LATENCY cycles later as a one-cycle rvalid_o pulse.

  localparam int IW = port_idx_w(NUM_PORTS);

  logic [IW-1:0]        rr_ptr, lock_owner, pick_ptr, pick_idx, win_idx, ptr_next;
  logic                 lock_valid, lock_hit, pick_any, win_any;
  logic [NUM_PORTS-1:0] pick_gnt, win_gnt;
  ret_slot_t            ret_pipe [READ_LATENCY];
  ret_slot_t            push_slot, ret_tail;

  assign pick_ptr = (PRIO_MODE == PRIO_RR) ? rr_ptr : '0;

  mem_arb_rr_picker #(.N(NUM_PORTS), .IW(IW)) u_picker (
    .req (req_i),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The owner keeps the bus only while it still asserts both req and lock.
  assign lock_hit = lock_valid && req_i[lock_owner] && lock_i[lock_owner];

  always_comb begin
    win_gnt = pick_gnt;
    win_idx = pick_idx;
    win_any = pick_any;
    if (lock_hit) begin
      win_gnt             = '0;
      win_gnt[lock_owner] = 1'b1;
      win_idx             = lock_owner;
      win_any             = 1'b1;
    end
    if (rst_i) begin
      win_gnt = '0;
      win_any = 1'b0;
    end
  end

  assign gnt_o        = win_gnt;
  assign mem_rd_en_o  = win_any && !we_i[win_idx];
  assign mem_wr_en_o  = win_any && we_i[win_idx];
  assign mem_enable_o = mem_rd_en_o || mem_wr_en_o;
  assign mem_addr_o   = win_any ? addr_i[win_idx] : '0;
  assign mem_value_o  = win_any ? wdata_i[win_idx] : '0;

  assign ptr_next = (win_idx == IW'(NUM_PORTS - 1)) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_owner <= '0;
    end else begin
      if (win_any && !lock_hit) rr_ptr <= ptr_next;
      if (win_any && lock_i[win_idx]) begin
        lock_valid <= 1'b1;
        lock_owner <= win_idx;
      end else begin
        lock_valid <= 1'b0;
      end
    end
  end

  assign push_slot.valid = win_any && !we_i[win_idx];
  assign push_slot.idx   = IDX_MAX_W'(win_idx);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < READ_LATENCY; i++) ret_pipe[i] <= '0;
    end else begin
      ret_pipe[0] <= push_slot;
      for (int i = 1; i < READ_LATENCY; i++) ret_pipe[i] <= ret_pipe[i-1];
    end
  end

  assign ret_tail = ret_pipe[READ_LATENCY-1];

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      rvalid_o[i] = !rst_i && ret_tail.valid && (ret_tail.idx == IDX_MAX_W'(i));
  end

  assign rdata_o = rst_i ? '0 : mem_value_i;

endmodule
